acct_policy_loader: RTL and testbench

Boot-time sequencer for the access-control register file. After `start_i`, it performs these steps:
- Fetches NB_WORDS policy words from a policy source through a valid/ready handshake.
- Writes each word over a register-bus master port, then reads it back and compares.
- Once every word verifies, drives the register-lock vector so the policy is frozen until the next system reset.
- On a fetch timeout or exhausted retries, it still locks (fail-secure) and reports the failing index.

---
 rtl/acct_loader_pkg.sv | 22 ++
 rtl/acct_policy_loader.sv | 184 ++++++++++++++++++
 tb/tb_acct_policy_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acct_loader_pkg.sv
// Shared types and helpers for the access-control policy loader.
package acct_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_LOCK,
    S_DONE,
    S_FAIL
  } ldr_state_e;

  localparam logic [7:0] LOCK_MASK_DEFAULT = 8'hFF;

  // Byte address of a 32-bit policy word; callers truncate to their bus width.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/acct_policy_loader.sv
// Boot-time sequencer: fetch policy words, write and verify them on the register bus,
// then freeze the access-control file by driving the lock vector (also on failure).
module acct_policy_loader
  import acct_loader_pkg::*;
#(
  parameter int         NB_WORDS      = 12,
  parameter int         AW            = 10,
  parameter int         BASE_ADDR     = 0,
  parameter int         MAX_RETRY     = 2,
  parameter int         FETCH_TIMEOUT = 255,
  parameter logic [7:0] LOCK_MASK     = LOCK_MASK_DEFAULT,
  localparam int        IW            = $clog2(NB_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          pol_req_o,
  output logic [IW-1:0] pol_idx_o,
  input  logic          pol_valid_i,
  input  logic [31:0]   pol_data_i,
  output logic          reg_valid_o,
  output logic          reg_write_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [31:0]   reg_wdata_o,
  input  logic          reg_ready_i,
  input  logic [31:0]   reg_rdata_i,
  input  logic          reg_error_i,
  output logic [7:0]    reglk_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          fail_o,
  output logic [IW-1:0] fail_idx_o
);

  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  if (BASE_ADDR + 4 * (NB_WORDS - 1) >= (1 << AW)) begin : g_addr_range
    $error("policy address range does not fit in AW bits");
  end

  ldr_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    reglk_q, reglk_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [IW-1:0] fail_idx_q, fail_idx_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;
  logic          retry_req;
  logic          go_fail;
  logic [TW-1:0] tmo_inc;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    reglk_d    = reglk_q;
    done_d     = done_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    retry_req  = 1'b0;
    go_fail    = 1'b0;
    tmo_inc    = tmo_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end
      S_FETCH: begin
        if (pol_valid_i) begin
          word_d  = pol_data_i;
          retry_d = '0;
          state_d = S_WRITE;
        end else if (tmo_inc == TW'(FETCH_TIMEOUT)) begin
          go_fail = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_WRITE: begin
        if (reg_ready_i) begin
          if (reg_error_i) retry_req = 1'b1;
          else             state_d   = S_READ;
        end
      end
      S_READ: begin
        if (reg_ready_i) begin
          rdata_d = reg_rdata_i;
          rerr_d  = reg_error_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!rerr_q && (rdata_q == word_q)) begin
          if (idx_q < IW'(NB_WORDS - 1)) begin
            idx_d   = idx_q + 1'b1;
            tmo_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_LOCK;
          end
        end else begin
          retry_req = 1'b1;
        end
      end
      S_LOCK: begin
        reglk_d = LOCK_MASK;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: ;
    endcase

    // Retries reuse the latched word; only a fresh index triggers a refetch.
    if (retry_req) begin
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        state_d = S_WRITE;
      end else begin
        go_fail = 1'b1;
      end
    end

    if (go_fail) begin
      state_d    = S_FAIL;
      fail_d     = 1'b1;
      fail_idx_d = idx_q;
      reglk_d    = LOCK_MASK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      reglk_q    <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      reglk_q    <= reglk_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    word_q  <= word_d;
    rdata_q <= rdata_d;
    rerr_q  <= rerr_d;
  end

  assign pol_req_o   = (state_q == S_FETCH);
  assign pol_idx_o   = idx_q;
  assign reg_valid_o = (state_q == S_WRITE) || (state_q == S_READ);
  assign reg_write_o = (state_q == S_WRITE);
  assign reg_addr_o  = AW'(word_addr(32'(BASE_ADDR), 32'(idx_q)));
  assign reg_wdata_o = word_q;
  assign reglk_o     = reglk_q;
  assign busy_o      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_idx_o  = fail_idx_q;

endmodule

// File: tb/tb_acct_policy_loader.sv
// Scoreboard bench for acct_policy_loader: bus/source models, expected transaction queue and end-state checks.
module tb_acct_policy_loader;

  localparam int NB   = 12;
  localparam int AW   = 10;
  localparam int MAXR = 2;
  localparam int TMO  = 255;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          pol_req_o, pol_valid_i;
  logic [3:0]    pol_idx_o, fail_idx_o;
  logic [31:0]   pol_data_i, reg_wdata_o, reg_rdata_i;
  logic          reg_valid_o, reg_write_o, reg_ready_i, reg_error_i;
  logic [AW-1:0] reg_addr_o;
  logic [7:0]    reglk_o;
  logic          busy_o, done_o, fail_o;

  always #5 clk = ~clk;

  acct_policy_loader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .pol_req_o(pol_req_o), .pol_idx_o(pol_idx_o), .pol_valid_i(pol_valid_i), .pol_data_i(pol_data_i),
    .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i),
    .reg_error_i(reg_error_i), .reglk_o(reglk_o), .busy_o(busy_o), .done_o(done_o),
    .fail_o(fail_o), .fail_idx_o(fail_idx_o)
  );

  // Environment models
  logic [31:0] src [16];
  logic [31:0] mem [16];
  int          rd_cnt [16];
  int          corrupt_n [16];
  int          stall = 0, vdly = 0, miss_idx = -1;
  int          wait_cnt = 0, fwait = 0;
  longint      cyc = 0;
  logic [3:0]  widx;

  assign widx        = reg_addr_o[5:2];
  assign reg_ready_i = reg_valid_o && (wait_cnt >= stall);
  assign reg_error_i = 1'b0;
  assign reg_rdata_i = mem[widx] ^ ((rd_cnt[widx] < corrupt_n[widx]) ? 32'hDEAD_BEEF : 32'h0);
  assign pol_valid_i = pol_req_o && (fwait >= vdly) && (int'(pol_idx_o) != miss_idx);
  assign pol_data_i  = src[pol_idx_o];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_i) begin
      wait_cnt <= 0;
      fwait    <= 0;
      for (int i = 0; i < 16; i++) rd_cnt[i] <= 0;
    end else begin
      if (reg_valid_o && reg_ready_i) begin
        wait_cnt <= 0;
        if (reg_write_o) mem[widx] <= reg_wdata_o;
        else             rd_cnt[widx] <= rd_cnt[widx] + 1;
      end else if (reg_valid_o) wait_cnt <= wait_cnt + 1;
      else                      wait_cnt <= 0;
      if (pol_req_o && pol_valid_i) fwait <= 0;
      else if (pol_req_o)           fwait <= fwait + 1;
      else                          fwait <= 0;
    end
  end

  // Scoreboard
  int   n_cmp = 0, n_bad = 0;
  txn_t exp_q [$];
  txn_t hold;
  logic hold_v = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    txn_t cur;
    txn_t e;
    cur = '{wr: reg_write_o, addr: reg_addr_o, data: reg_wdata_o};
    if (reg_valid_o) begin
      if (hold_v) chk("stall_stable", cur, hold);
      if (reg_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_txn: got wr=%0b addr=%0h, required no transaction", reg_write_o, reg_addr_o);
        end else begin
          e = exp_q.pop_front();
          chk("txn_wr", reg_write_o, e.wr);
          chk("txn_addr", reg_addr_o, e.addr);
          if (e.wr) chk("txn_wdata", reg_wdata_o, e.data);
        end
        hold_v <= 1'b0;
      end else begin
        hold_v <= 1'b1;
        hold   <= cur;
      end
    end else begin
      hold_v <= 1'b0;
    end
  end

  // Expected end state of the current scenario
  int exp_cyc, exp_fidx;
  bit exp_fail;

  task automatic check_zero(input string tag);
    chk({tag, "_reglk"}, reglk_o, 8'h00);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_fail"}, fail_o, 1'b0);
    chk({tag, "_fail_idx"}, fail_idx_o, 4'd0);
    chk({tag, "_pol_req"}, pol_req_o, 1'b0);
    chk({tag, "_reg_valid"}, reg_valid_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i   = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  // Model: each word costs its fetch wait plus per attempt a write, a read and a check.
  task automatic prep(input int st, input int vd, input int miss, input int cw, input int cn, input bit nominal);
    int  t;
    bit  fin;
    do_reset();
    stall    = st;
    vdly     = vd;
    miss_idx = miss;
    for (int i = 0; i < 16; i++) corrupt_n[i] = 0;
    corrupt_n[cw] = cn;
    for (int i = 0; i < NB; i++) src[i] = nominal ? (32'hA5A5_0000 + 32'(i)) : $urandom;
    t = 0; fin = 0; exp_fail = 0; exp_fidx = 0; exp_cyc = 0;
    for (int i = 0; i < NB && !fin; i++) begin
      if (i == miss) begin
        exp_fail = 1; exp_fidx = i; exp_cyc = 1 + t + TMO; fin = 1;
      end else begin
        t += 1 + vd;
        for (int a = 0; a <= MAXR; a++) begin
          exp_q.push_back('{wr: 1'b1, addr: AW'(4 * i), data: src[i]});
          exp_q.push_back('{wr: 1'b0, addr: AW'(4 * i), data: src[i]});
          t += 2 * (1 + st) + 1;
          if (a >= corrupt_n[i]) break;
          if (a == MAXR) begin
            exp_fail = 1; exp_fidx = i; exp_cyc = 1 + t; fin = 1;
          end
        end
      end
    end
    if (!exp_fail) exp_cyc = 2 + t;
  endtask

  task automatic start_and_check(input bit poke);
    longint t0;
    int     got;
    @(negedge clk);
    start_i = 1'b1;
    t0 = cyc;
    got = -1;
    for (int k = 1; k < 4000; k++) begin
      @(negedge clk);
      start_i = poke && ((cyc - t0) == 10);
      if (done_o || fail_o) begin
        got = int'(cyc - t0);
        break;
      end
    end
    start_i = 1'b0;
    if (got < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL end_wait: no done/fail within bound, required cycle %0d", exp_cyc);
    end
    chk("end_cycle", got, exp_cyc);
    chk("done", done_o, !exp_fail);
    chk("fail", fail_o, exp_fail);
    if (exp_fail) chk("fail_idx", fail_idx_o, exp_fidx);
    chk("reglk", reglk_o, 8'hFF);
    chk("busy_end", busy_o, 1'b0);
    repeat (2) @(negedge clk);
    if (poke) begin
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      chk("done_hold", done_o, !exp_fail);
      chk("busy_hold", busy_o, 1'b0);
    end
    chk("queue_drained", exp_q.size(), 0);
    if (!exp_fail)
      for (int i = 0; i < NB; i++) chk("mem_word", mem[i], src[i]);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);

    // Nominal, done at cycle 50; start pokes while busy and in DONE are ignored
    prep(0, 0, -1, 0, 0, 1'b1);
    start_and_check(1'b1);

    // Bus backpressure: 3 stall cycles per transaction
    prep(3, 0, -1, 0, 0, 1'b1);
    start_and_check(1'b0);

    // Readback mismatch recovered on third attempt
    prep(0, 0, -1, 5, 2, 1'b1);
    start_and_check(1'b0);

    // Retries exhausted on word 5
    prep(0, 0, -1, 5, 3, 1'b1);
    start_and_check(1'b0);

    // Fetch timeout on word 3
    prep(0, 0, 3, 0, 0, 1'b1);
    start_and_check(1'b0);

    // Reset during the read of word 7, then a fresh run
    prep(0, 0, -1, 0, 0, 1'b1);
    @(negedge clk);
    start_i = 1'b1;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (reg_valid_o && !reg_write_o && pol_idx_o == 4'd7) found = 1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL midop_wait: read of word 7 not seen, required within 200 cycles");
    end
    rst_i = 1'b1;
    @(negedge clk);
    check_zero("midop");
    rst_i = 1'b0;
    exp_q.delete();
    prep(0, 0, -1, 0, 0, 1'b1);
    start_and_check(1'b0);

    // Randomized scenarios
    for (int r = 0; r < 6; r++) begin
      int st, vd, cw, cn, ms;
      st = $urandom_range(0, 3);
      vd = $urandom_range(0, 2);
      cw = $urandom_range(0, NB - 1);
      cn = $urandom_range(0, 3);
      ms = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 1) : -1;
      prep(st, vd, ms, cw, cn, 1'b0);
      start_and_check(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
